uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_baud_tick.sv | 17 +
 rtl/uart_rx.sv | 126 ++++++++++++
 tb/tb_uart_rx.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding, tick-divisor helper and default oversampling ratio.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_e;
  localparam int UART_OVERSAMPLE = 16;
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider, tick_o high one cycle every DIV clocks.
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == W'(DIV - 1);
  always_comb cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with valid/ready output; define UART_RX_PARITY_EN for even parity.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 RXD_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif
  logic                 tick, rx, mid, last;
  logic [1:0]           sync_q, sync_d;
  rx_state_e            state_q, state_d;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, data_q, data_d;
  logic                 perr_q, perr_d, valid_q, valid_d;
  logic                 ferr_q, ferr_d, perr_p_q, perr_p_d, ovr_q, ovr_d;
  uart_baud_tick #(.DIV(DIV)) u_tick (.clk_i(clk_i), .rst_i(rst_i), .tick_o(tick));
  assign rx   = sync_q[1];
  assign mid  = scnt_q == SW'(OVERSAMPLE / 2 - 1);
  assign last = scnt_q == SW'(OVERSAMPLE - 1);
  always_comb begin
    sync_d   = {sync_q[0], RXD_i};
    state_d  = state_q;
    scnt_d   = scnt_q;
    bcnt_d   = bcnt_q;
    shreg_d  = shreg_q;
    perr_d   = perr_q;
    data_d   = data_q;
    valid_d  = valid_q & ~ready_i;
    ferr_d   = 1'b0;
    perr_p_d = 1'b0;
    ovr_d    = 1'b0;
    if (tick) begin
      scnt_d = last ? '0 : scnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          scnt_d  = '0;
          state_d = rx ? IDLE : START;
        end
        START: if (mid) begin
          state_d = rx ? IDLE : DATA;
          scnt_d  = '0;
          bcnt_d  = '0;
        end
        DATA: if (last) begin
          shreg_d = {rx, shreg_q[DATA_BITS-1:1]};
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == BW'(DATA_BITS - 1)) state_d = PAR_EN ? PARITY : STOP;
        end
        PARITY: if (last) begin
          perr_d  = rx ^ (^shreg_q);
          state_d = STOP;
        end
        // A low stop bit discards the byte and parks in BREAK until the line recovers.
        STOP: if (last) begin
          perr_p_d = perr_q;
          state_d  = rx ? IDLE : BREAK;
          ferr_d   = ~rx;
          if (rx && (!valid_q || ready_i)) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end
          ovr_d = rx & valid_q & ~ready_i;
        end
        BREAK: begin
          scnt_d  = '0;
          state_d = rx ? IDLE : BREAK;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q   <= 2'b11;
      state_q  <= IDLE;
      scnt_q   <= '0;
      bcnt_q   <= '0;
      shreg_q  <= '0;
      perr_q   <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      perr_p_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      bcnt_q   <= bcnt_d;
      shreg_q  <= shreg_d;
      perr_q   <= perr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      perr_p_q <= perr_p_d;
      ovr_q    <= ovr_d;
    end
  end
  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign frame_err_o  = ferr_q;
  assign parity_err_o = PAR_EN & perr_p_q;
  assign overrun_o    = ovr_q;
  assign busy_o       = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames at 160 clocks/bit; parity cases run when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
  logic       clk = 1'b0, rst_n = 1'b0, rxd = 1'b1, ready = 1'b1;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, parity_err_o, overrun_o, busy_o;
  int         n_cmp = 0, n_err = 0;
  int         v_rise = 0, v_cyc = 0, fe = 0, pe = 0, ov = 0;
  logic       v_prev = 1'b0;
  uart_rx #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk_i(clk), .rst_i(rst_n), .RXD_i(rxd), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready), .frame_err_o(frame_err_o), .parity_err_o(parity_err_o),
    .overrun_o(overrun_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    v_cyc  += int'(valid_o);
    v_rise += int'(valid_o && !v_prev);
    v_prev  = valid_o;
    fe     += int'(frame_err_o);
    pe     += int'(parity_err_o);
    ov     += int'(overrun_o);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    @(posedge clk);
    v_rise = 0; v_cyc = 0; fe = 0; pe = 0; ov = 0;
  endtask
  task automatic bit_t(input logic v);
    rxd = v;
    repeat (160) @(posedge clk);
  endtask
  task automatic send(input logic [7:0] d, input logic flip);
    bit_t(1'b0);
    for (int i = 0; i < 8; i++) bit_t(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_t((^d) ^ flip);
`else
    if (flip) bit_t(1'b1);
`endif
    bit_t(1'b1);
    repeat (160) @(posedge clk);
  endtask
  task automatic chk_idle(input string tag);
    @(negedge clk);
    check({tag, "_data"}, 32'(data_o), 32'h0);
    check({tag, "_valid"}, 32'(valid_o), 32'h0);
    check({tag, "_busy"}, 32'(busy_o), 32'h0);
    check({tag, "_ferr"}, 32'(frame_err_o), 32'h0);
    check({tag, "_perr"}, 32'(parity_err_o), 32'h0);
    check({tag, "_ovr"}, 32'(overrun_o), 32'h0);
  endtask
  initial begin
    repeat (5) @(posedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    clr();
    send(8'hA5, 1'b0);
    check("a5_data", 32'(data_o), 32'hA5);
    check("a5_vrise", 32'(v_rise), 32'd1);
    check("a5_vcyc", 32'(v_cyc), 32'd1);
    check("a5_ferr", 32'(fe), 32'd0);
    check("a5_ovr", 32'(ov), 32'd0);
    check("a5_perr", 32'(pe), 32'd0);
    clr();
    rxd = 1'b0;
    repeat (40) @(posedge clk);
    rxd = 1'b1;
    repeat (400) @(posedge clk);
    @(negedge clk);
    check("glitch_busy", 32'(busy_o), 32'd0);
    check("glitch_vrise", 32'(v_rise), 32'd0);
    clr();
    bit_t(1'b0);
    for (int i = 0; i < 8; i++) bit_t(i inside {2, 3, 4, 5});
`ifdef UART_RX_PARITY_EN
    bit_t(1'b0);
`endif
    rxd = 1'b0;
    repeat (320) @(posedge clk);
    @(negedge clk);
    check("brk_busy", 32'(busy_o), 32'd1);
    check("brk_ferr", 32'(fe), 32'd1);
    rxd = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("brk_idle", 32'(busy_o), 32'd0);
    check("brk_vrise", 32'(v_rise), 32'd0);
    clr();
    send(8'h55, 1'b0);
    check("55_data", 32'(data_o), 32'h55);
    check("55_vrise", 32'(v_rise), 32'd1);
    check("55_ferr", 32'(fe), 32'd0);
    clr();
    ready = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    @(negedge clk);
    check("ovr_data", 32'(data_o), 32'h11);
    check("ovr_valid", 32'(valid_o), 32'd1);
    check("ovr_pulse", 32'(ov), 32'd1);
    check("ovr_vrise", 32'(v_rise), 32'd1);
    ready = 1'b1;
    @(negedge clk);
    check("ovr_drop", 32'(valid_o), 32'd0);
`ifdef UART_RX_PARITY_EN
    clr();
    send(8'h03, 1'b1);
    check("par_bad_data", 32'(data_o), 32'h03);
    check("par_bad_pulse", 32'(pe), 32'd1);
    check("par_bad_vrise", 32'(v_rise), 32'd1);
    clr();
    send(8'h03, 1'b0);
    check("par_ok_pulse", 32'(pe), 32'd0);
    check("par_ok_vrise", 32'(v_rise), 32'd1);
`endif
    clr();
    bit_t(1'b0);
    for (int i = 0; i < 4; i++) bit_t(1'b1);
    repeat (80) @(posedge clk);
    #2 rst_n = 1'b0;
    chk_idle("midrst");
    repeat (20) @(posedge clk);
    rst_n = 1'b1;
    repeat (800) @(posedge clk);
    @(negedge clk);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_vrise", 32'(v_rise), 32'd0);
    clr();
    send(8'h81, 1'b0);
    check("81_data", 32'(data_o), 32'h81);
    check("81_vrise", 32'(v_rise), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
